// File: rtl/nabp_pkg.sv
// Shared types and constants for the NABP angle scheduler: state encoding,
// angle-index width and the performance counter helpers.
package nabp_pkg;

  localparam int kNoOfAnglesLength = 8;
  localparam int kPerfCntW         = 32;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WAIT_FP = 3'd1,
    S_KICK    = 3'd2,
    S_BUSY    = 3'd3,
    S_ADVANCE = 3'd4,
    S_FINISH  = 3'd5
  } sched_state_e;

  // Counters stick at all-ones instead of wrapping back to zero
  function automatic logic [kPerfCntW-1:0] sat_inc(input logic [kPerfCntW-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/nabp_angle_scheduler_if.sv
// Host / filtered-projection buffer / image addresser signals of the scheduler.
// master = scheduler side, slave = surrounding logic. NABP_SCHED_PERF_EN adds perf counters.
interface nabp_angle_scheduler_if
  import nabp_pkg::*;
#(
  parameter int ANGLE_WIDTH = kNoOfAnglesLength
);
  logic                   start;
  logic                   abort;
  logic                   fp_valid;
  logic                   fp_ack;
  logic                   ir_kick;
  logic                   ir_done;
  logic [ANGLE_WIDTH-1:0] angle;
  logic                   busy;
  logic                   done;
  logic                   aborted;
`ifdef NABP_SCHED_PERF_EN
  logic [kPerfCntW-1:0]   stall_cycles;
  logic [kPerfCntW-1:0]   busy_cycles;

  modport master (
    input  start, abort, fp_valid, ir_done,
    output fp_ack, ir_kick, angle, busy, done, aborted, stall_cycles, busy_cycles
  );
  modport slave (
    output start, abort, fp_valid, ir_done,
    input  fp_ack, ir_kick, angle, busy, done, aborted, stall_cycles, busy_cycles
  );
`else
  modport master (
    input  start, abort, fp_valid, ir_done,
    output fp_ack, ir_kick, angle, busy, done, aborted
  );
  modport slave (
    output start, abort, fp_valid, ir_done,
    input  fp_ack, ir_kick, angle, busy, done, aborted
  );
`endif
endinterface

// File: rtl/nabp_angle_counter.sv
// Angle index register for the scheduler: clears to 0, increments without wrap,
// and flags the final angle of the run.
module nabp_angle_counter #(
  parameter int NO_OF_ANGLES = 180,
  parameter int ANGLE_WIDTH  = 8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   clear,
  input  logic                   inc,
  output logic [ANGLE_WIDTH-1:0] angle,
  output logic                   last
);

  localparam logic [ANGLE_WIDTH-1:0] kLastAngle = ANGLE_WIDTH'(NO_OF_ANGLES - 1);

  assign last = (angle == kLastAngle);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      angle <= '0;
    end else if (clear) begin
      angle <= '0;
    end else if (inc && !last) begin
      angle <= angle + 1'b1;
    end
  end

endmodule

// File: rtl/nabp_angle_scheduler.sv
// Per-angle sequencer for one NABP back-projection run: waits for a projection line,
// kicks the image addresser, waits for it, advances. NABP_SCHED_PERF_EN adds stall/busy counters.
module nabp_angle_scheduler
  import nabp_pkg::*;
#(
  parameter int NO_OF_ANGLES = 180,
  parameter int ANGLE_WIDTH  = kNoOfAnglesLength
) (
  input logic                   clk,
  input logic                   reset_n,
  nabp_angle_scheduler_if.master bus
);

  sched_state_e           state;
  sched_state_e           state_nxt;
  logic                   ang_clear;
  logic                   ang_inc;
  logic                   abort_take;
  logic                   ang_last;
  logic [ANGLE_WIDTH-1:0] ang;
  logic                   kick_q;
  logic                   busy_q;
  logic                   done_q;
  logic                   aborted_q;

  nabp_angle_counter #(
    .NO_OF_ANGLES (NO_OF_ANGLES),
    .ANGLE_WIDTH  (ANGLE_WIDTH)
  ) u_angle_counter (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (ang_clear),
    .inc     (ang_inc),
    .angle   (ang),
    .last    (ang_last)
  );

  // abort outranks every transition except the start decision in IDLE
  always_comb begin
    state_nxt  = state;
    ang_clear  = 1'b0;
    ang_inc    = 1'b0;
    abort_take = 1'b0;
    if (state != S_IDLE && bus.abort) begin
      state_nxt  = S_IDLE;
      ang_clear  = 1'b1;
      abort_take = 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            state_nxt = S_WAIT_FP;
            ang_clear = 1'b1;
          end
        end
        S_WAIT_FP: if (bus.fp_valid) state_nxt = S_KICK;
        S_KICK:    state_nxt = S_BUSY;
        S_BUSY:    if (bus.ir_done) state_nxt = S_ADVANCE;
        S_ADVANCE: begin
          if (ang_last) begin
            state_nxt = S_FINISH;
          end else begin
            state_nxt = S_WAIT_FP;
            ang_inc   = 1'b1;
          end
        end
        S_FINISH:  state_nxt = S_IDLE;
        default:   state_nxt = S_IDLE;
      endcase
    end
  end

  // Outputs are registered from the next state, so they track the state register exactly
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      kick_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      kick_q    <= (state_nxt == S_KICK);
      busy_q    <= (state_nxt != S_IDLE);
      done_q    <= (state_nxt == S_FINISH);
      aborted_q <= abort_take;
    end
  end

  assign bus.fp_ack  = kick_q;
  assign bus.ir_kick = kick_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.aborted = aborted_q;
  assign bus.angle   = ang;

`ifdef NABP_SCHED_PERF_EN
  logic [kPerfCntW-1:0] stall_cnt;
  logic [kPerfCntW-1:0] busy_cnt;

  // Counts are kept after the run ends and only cleared when the next run starts
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt <= '0;
      busy_cnt  <= '0;
    end else if (state == S_IDLE && state_nxt == S_WAIT_FP) begin
      stall_cnt <= '0;
      busy_cnt  <= '0;
    end else begin
      if (state == S_WAIT_FP && !bus.fp_valid) stall_cnt <= sat_inc(stall_cnt);
      if (state == S_BUSY)                     busy_cnt  <= sat_inc(busy_cnt);
    end
  end

  assign bus.stall_cycles = stall_cnt;
  assign bus.busy_cycles  = busy_cnt;
`endif

endmodule

// File: tb/tb_nabp_angle_scheduler.sv
// Bench for nabp_angle_scheduler: a 4-angle instance driven by a cycle table and run
// sequences, plus a 1-angle instance; kicks are checked against an expected-angle queue.
module tb_nabp_angle_scheduler;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  nabp_angle_scheduler_if #(.ANGLE_WIDTH(8)) bus0 ();
  nabp_angle_scheduler_if #(.ANGLE_WIDTH(8)) bus1 ();

  nabp_angle_scheduler #(.NO_OF_ANGLES(4), .ANGLE_WIDTH(8)) dut0 (
    .clk(clk), .reset_n(reset_n), .bus(bus0.master)
  );
  nabp_angle_scheduler #(.NO_OF_ANGLES(1), .ANGLE_WIDTH(8)) dut1 (
    .clk(clk), .reset_n(reset_n), .bus(bus1.master)
  );

  typedef struct {
    logic       start, abort, fv, ird;
    logic       busy, kick, ack, done, aborted;
    logic [7:0] angle;
  } vec_t;

  vec_t tbl [20];

  int tests = 0;
  int fails = 0;
  int kicks0 = 0, acks0 = 0, dones0 = 0, aborts0 = 0;
  int kicks1 = 0, dones1 = 0;
  int dn0 = 0, dn1 = 0;
  bit auto0 = 1'b0, auto1 = 1'b0;
  int exp0 [$];
  int exp1 [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // One clock: sample just after the edge, run the ir_done responders, score kicks
  task automatic tick();
    @(posedge clk);
    #1;
    if (auto0) begin
      if (bus0.ir_done) bus0.ir_done = 1'b0;
      if (dn0 > 0) begin
        dn0--;
        if (dn0 == 0) bus0.ir_done = 1'b1;
      end
    end
    if (auto1) begin
      if (bus1.ir_done) bus1.ir_done = 1'b0;
      if (dn1 > 0) begin
        dn1--;
        if (dn1 == 0) bus1.ir_done = 1'b1;
      end
    end
    if (bus0.ir_kick === 1'b1) begin
      kicks0++;
      if (auto0) dn0 = 3;
      if (exp0.size() == 0) begin
        tests++; fails++;
        $display("FAIL kick0_unexpected: got kick at angle %0d, expected no kick", bus0.angle);
      end else begin
        check("kick0_angle", bus0.angle, exp0.pop_front());
      end
    end
    if (bus1.ir_kick === 1'b1) begin
      kicks1++;
      if (auto1) dn1 = 3;
      if (exp1.size() == 0) begin
        tests++; fails++;
        $display("FAIL kick1_unexpected: got kick at angle %0d, expected no kick", bus1.angle);
      end else begin
        check("kick1_angle", bus1.angle, exp1.pop_front());
      end
    end
    if (bus0.fp_ack === 1'b1)  acks0++;
    if (bus0.done === 1'b1)    dones0++;
    if (bus0.aborted === 1'b1) aborts0++;
    if (bus1.done === 1'b1)    dones1++;
  endtask

  // Full run on dut0 with fp_valid tied high and ir_done 3 cycles after each kick
  task automatic run0(input int n);
    int k0, a0, d0, t, lat;
    k0 = kicks0; a0 = acks0; d0 = dones0; t = 0; lat = -1;
    for (int i = 0; i < n; i++) exp0.push_back(i);
    bus0.fp_valid = 1'b1;
    auto0 = 1'b1;
    bus0.start = 1'b1;
    while (1) begin
      tick();
      t++;
      bus0.start = 1'b0;
      if (lat < 0 && kicks0 != k0) lat = t;
      if (dones0 != d0) break;
      if (t > 500) begin
        tests++; fails++;
        $display("FAIL run0_timeout: got no done after %0d cycles, expected done", t);
        break;
      end
    end
    check("run0_first_kick_latency", lat, 2);
    check("run0_kicks", kicks0 - k0, n);
    check("run0_acks", acks0 - a0, n);
    check("run0_done_angle", bus0.angle, n - 1);
    check("run0_busy_at_done", bus0.busy, 1'b1);
    tick();
    check("run0_busy_after", bus0.busy, 1'b0);
    check("run0_done_pulse", bus0.done, 1'b0);
    check("run0_done_count", dones0 - d0, 1);
    auto0 = 1'b0;
    dn0 = 0;
    bus0.ir_done = 1'b0;
    bus0.fp_valid = 1'b0;
  endtask

  initial begin
    int k, t, d;
    // start abort fv ird | busy kick ack done aborted angle
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
    tbl[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
    tbl[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
    tbl[4]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0};
    tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
    tbl[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
    tbl[7]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
    tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1};
    tbl[9]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd1};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1};
    tbl[11] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1};
    tbl[12] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd2};
    tbl[13] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd2};
    tbl[14] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd2};
    tbl[15] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0};
    tbl[16] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
    tbl[17] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
    tbl[18] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
    tbl[19] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0};

    bus0.start = 1'b0; bus0.abort = 1'b0; bus0.fp_valid = 1'b0; bus0.ir_done = 1'b0;
    bus1.start = 1'b0; bus1.abort = 1'b0; bus1.fp_valid = 1'b0; bus1.ir_done = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", bus0.busy, 1'b0);
    check("reset_kick", bus0.ir_kick, 1'b0);
    check("reset_ack", bus0.fp_ack, 1'b0);
    check("reset_done", bus0.done, 1'b0);
    check("reset_aborted", bus0.aborted, 1'b0);
    check("reset_angle", bus0.angle, 8'd0);
    reset_n = 1'b1;
    tick();

    // Four-angle run
    run0(4);

    // Cycle table: stall, spurious ir_done/start, abort with ir_done, abort vs start in IDLE
    exp0.push_back(0); exp0.push_back(1); exp0.push_back(2);
    d = dones0;
    for (int i = 0; i < 20; i++) begin
      bus0.start = tbl[i].start; bus0.abort = tbl[i].abort;
      bus0.fp_valid = tbl[i].fv; bus0.ir_done = tbl[i].ird;
      tick();
      check($sformatf("tbl%0d_busy", i), bus0.busy, tbl[i].busy);
      check($sformatf("tbl%0d_kick", i), bus0.ir_kick, tbl[i].kick);
      check($sformatf("tbl%0d_ack", i), bus0.fp_ack, tbl[i].ack);
      check($sformatf("tbl%0d_done", i), bus0.done, tbl[i].done);
      check($sformatf("tbl%0d_aborted", i), bus0.aborted, tbl[i].aborted);
      check($sformatf("tbl%0d_angle", i), bus0.angle, tbl[i].angle);
    end
    bus0.start = 1'b0; bus0.abort = 1'b0; bus0.fp_valid = 1'b0; bus0.ir_done = 1'b0;
    check("tbl_no_done", dones0 - d, 0);

    // Stall in WAIT_FP for 10 cycles, then release
    exp0.push_back(0);
    k = kicks0;
    bus0.start = 1'b1;
    tick();
    bus0.start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("stall_busy", bus0.busy, 1'b1);
    end
    check("stall_no_kick", kicks0 - k, 0);
    check("stall_angle", bus0.angle, 8'd0);
`ifdef NABP_SCHED_PERF_EN
    check("stall_cycles", bus0.stall_cycles, 32'd10);
`endif
    bus0.fp_valid = 1'b1;
    tick();
    check("stall_release_kick", bus0.ir_kick, 1'b1);
    bus0.fp_valid = 1'b0;
    tick();
    bus0.abort = 1'b1;
    tick();
    bus0.abort = 1'b0;
    check("stall_abort_pulse", bus0.aborted, 1'b1);
    check("stall_abort_idle", bus0.busy, 1'b0);

    // Asynchronous reset while BUSY at angle 1
    exp0.push_back(0); exp0.push_back(1);
    k = kicks0; t = 0;
    bus0.fp_valid = 1'b1; auto0 = 1'b1; bus0.start = 1'b1;
    while (kicks0 - k < 2 && t < 100) begin
      tick();
      bus0.start = 1'b0;
      t++;
    end
    check("arst_setup_kicks", kicks0 - k, 2);
    auto0 = 1'b0; dn0 = 0; bus0.ir_done = 1'b0; bus0.fp_valid = 1'b0;
    tick();
    check("arst_pre_busy", bus0.busy, 1'b1);
    check("arst_pre_angle", bus0.angle, 8'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_busy", bus0.busy, 1'b0);
    check("arst_angle", bus0.angle, 8'd0);
    check("arst_kick", bus0.ir_kick, 1'b0);
    check("arst_done", bus0.done, 1'b0);
    check("arst_aborted", bus0.aborted, 1'b0);
    tick();
    reset_n = 1'b1;
    tick();
    run0(4);

    // Single-angle instance
    exp1.push_back(0);
    k = kicks1; d = dones1; t = 0;
    bus1.fp_valid = 1'b1; auto1 = 1'b1; bus1.start = 1'b1;
    while (dones1 == d && t < 100) begin
      tick();
      bus1.start = 1'b0;
      t++;
    end
    check("one_done", dones1 - d, 1);
    check("one_kicks", kicks1 - k, 1);
    check("one_angle", bus1.angle, 8'd0);
    tick();
    check("one_busy_after", bus1.busy, 1'b0);
    auto1 = 1'b0; bus1.ir_done = 1'b0; bus1.fp_valid = 1'b0;

    check("sb0_drained", exp0.size(), 0);
    check("sb1_drained", exp1.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
